// File: rtl/uart_lite_io_engine.sv
// rtl/uart_lite_io_engine.sv - UART-lite AXI-Lite master with local TX byte and RX word FIFOs
module uart_lite_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

module uart_lite_io_engine #(
    parameter int TX_DEPTH        = 16,
    parameter int RX_DEPTH        = 8,
    parameter int WORD_BYTES      = 4,
    parameter int UART_FIFO_DEPTH = 16,
    parameter bit SYNC_EN         = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    tx_valid,
    input  logic [7:0]              tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [8*WORD_BYTES-1:0] rx_data,
    input  logic                    rx_ready,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [31:0]             axi_awaddr,
    output logic [2:0]              axi_awprot,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [31:0]             axi_wdata,
    output logic [3:0]              axi_wstrb,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    output logic [31:0]             axi_araddr,
    output logic [2:0]              axi_arprot,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    input  logic [31:0]             axi_rdata,
    input  logic [1:0]              axi_rresp
);
    localparam int          CW        = $clog2(UART_FIFO_DEPTH + 1);
    localparam int          WW        = 8 * WORD_BYTES;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);
    localparam logic [31:0] ADDR_RX   = 32'h0;
    localparam logic [31:0] ADDR_TX   = 32'h4;
    localparam logic [31:0] ADDR_STAT = 32'h8;

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, ST_AR, ST_R, RX_AR, RX_R} state_t;

    state_t          state;
    logic [CW-1:0]   credit;
    logic            sync_pending;
    logic            last_was_write;
    logic            wr_is_sync;
    logic [1:0]      byte_cnt;
    logic [WW-1:0]   word_buf;
    logic [WW-1:0]   word_next;
    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]      tx_head;
    logic            rx_push, rx_pop, rx_full, rx_empty;
    logic            unused_inputs;

    assign unused_inputs = ^{axi_bresp, axi_rresp, axi_rdata[31:8]};
    assign axi_wstrb  = 4'b1111;
    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = (state == WR_RESP) && axi_bvalid && !wr_is_sync;
    assign rx_pop   = rx_ready && rx_valid;
    assign rx_push  = (state == RX_R) && axi_rvalid && (byte_cnt == LAST_BYTE);

    always_comb begin
        word_next = word_buf;
        word_next[int'(byte_cnt)*8 +: 8] = axi_rdata[7:0];
    end

    uart_lite_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push), .push_data(tx_data), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_lite_fifo #(.WIDTH(WW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push), .push_data(word_next), .pop(rx_pop),
        .head(rx_data), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            axi_awvalid    <= 1'b0;
            axi_wvalid     <= 1'b0;
            axi_bready     <= 1'b0;
            axi_arvalid    <= 1'b0;
            axi_rready     <= 1'b0;
            axi_awaddr     <= '0;
            axi_araddr     <= '0;
            axi_wdata      <= '0;
            credit         <= '0;
            sync_pending   <= SYNC_EN;
            last_was_write <= 1'b0;
            wr_is_sync     <= 1'b0;
            byte_cnt       <= '0;
            word_buf       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Back-to-back writes are never issued: a status poll always sits between them.
                    if ((sync_pending || !tx_empty) && credit != '0 && !last_was_write) begin
                        axi_awvalid    <= 1'b1;
                        axi_wvalid     <= 1'b1;
                        axi_awaddr     <= ADDR_TX;
                        axi_wdata      <= {24'b0, sync_pending ? 8'hAA : tx_head};
                        wr_is_sync     <= sync_pending;
                        last_was_write <= 1'b1;
                        state          <= WR_ADDR_DATA;
                    end else begin
                        axi_arvalid    <= 1'b1;
                        axi_araddr     <= ADDR_STAT;
                        last_was_write <= 1'b0;
                        state          <= ST_AR;
                    end
                end
                WR_ADDR_DATA: begin
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (wr_is_sync) sync_pending <= 1'b0;
                        if (credit != '0) credit <= credit - 1'b1;
                        state <= IDLE;
                    end
                end
                ST_AR, RX_AR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= (state == ST_AR) ? ST_R : RX_R;
                    end
                end
                ST_R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        if (axi_rdata[2])      credit <= CW'(UART_FIFO_DEPTH);
                        else if (axi_rdata[3]) credit <= '0;
                        // Only fetch an RX byte when the assembled word is guaranteed a slot.
                        if (axi_rdata[0] && !rx_full) begin
                            axi_arvalid <= 1'b1;
                            axi_araddr  <= ADDR_RX;
                            state       <= RX_AR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RX_R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        word_buf   <= word_next;
                        byte_cnt   <= (byte_cnt == LAST_BYTE) ? 2'd0 : byte_cnt + 2'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_lite_io_engine.sv
// tb/tb_uart_lite_io_engine.sv - directed bench for uart_lite_io_engine acting as the AXI-Lite slave
module tb_uart_lite_io_engine;
    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [1:0]  axi_bresp, axi_rresp;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    string step = "init";

    always #5 clk = ~clk;

    uart_lite_io_engine dut (
        .clk(clk), .rstn(rstn),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic serve_read(input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        while (axi_arvalid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ar_seen", axi_arvalid, 1);
        chk("araddr", axi_araddr, addr);
        chk("aw_idle", axi_awvalid, 0);
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        chk("ar_drop_rready", {axi_arvalid, axi_rready}, 2'b01);
        axi_rvalid = 1'b1;
        axi_rdata  = data;
        @(negedge clk);
        axi_rvalid = 1'b0;
        axi_rdata  = 32'h0;
        chk("rready_drop", axi_rready, 0);
    endtask

    task automatic serve_write(input logic [7:0] b, input int aw_dly, input int w_dly);
        int n;
        int last;
        n = 0;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        while (axi_awvalid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("aw_seen", {axi_awvalid, axi_wvalid, axi_arvalid}, 3'b110);
        chk("awaddr", axi_awaddr, 32'h4);
        chk("wdata", axi_wdata, {24'b0, b});
        chk("wstrb", axi_wstrb, 4'hF);
        for (int c = 0; c <= last; c++) begin
            axi_awready = (c == aw_dly);
            axi_wready  = (c == w_dly);
            @(negedge clk);
            chk("awvalid", axi_awvalid, (c < aw_dly));
            chk("wvalid", axi_wvalid, (c < w_dly));
            chk("bready", axi_bready, (c == last));
        end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b1;
        axi_bresp   = 2'b10;
        @(negedge clk);
        axi_bvalid  = 1'b0;
        chk("bready_drop", axi_bready, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 5'b0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_txrx", {tx_ready, rx_valid}, 2'b10);
        chk("rst_const", {axi_wstrb, axi_awprot, axi_arprot}, {4'hF, 6'b0});
    endtask

    initial begin
        rstn = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h0; rx_ready = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b0;
        repeat (3) @(negedge clk);
        step = "reset";
        check_reset_outputs();
        rstn = 1'b1;

        step = "sync";
        serve_read(32'h8, 32'h4);
        serve_write(8'hAA, 0, 0);

        step = "tx_fill";
        for (int i = 0; i < 18; i++) begin
            chk("tx_ready", tx_ready, (i < 16));
            push_byte(8'(8'h10 + i));
        end
        step = "tx_drain";
        for (int j = 0; j < 20; j++) begin
            serve_read(32'h8, 32'h4);
            serve_write(8'(8'h10 + j), 0, 0);
            if (j == 0) chk("tx_ready_after_pop", tx_ready, 1);
            if (j < 4) push_byte(8'(8'h20 + j));
        end

        step = "credit";
        for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
        serve_read(32'h8, 32'h4);
        serve_write(8'h30, 0, 0);
        for (int j = 1; j < 16; j++) begin
            serve_read(32'h8, 32'h0);
            serve_write(8'(8'h30 + j), 0, 0);
        end
        push_byte(8'h40);
        serve_read(32'h8, 32'h0);
        @(negedge clk);
        chk("no_write_credit0", {axi_awvalid, axi_arvalid}, 2'b01);
        serve_read(32'h8, 32'h0);
        serve_read(32'h8, 32'h4);
        serve_write(8'h40, 0, 0);

        step = "status_prio";
        push_byte(8'h41);
        serve_read(32'h8, 32'hC);
        serve_write(8'h41, 0, 0);
        push_byte(8'h42);
        serve_read(32'h8, 32'h8);
        @(negedge clk);
        chk("no_write_full", {axi_awvalid, axi_arvalid}, 2'b01);
        serve_read(32'h8, 32'h4);
        serve_write(8'h42, 0, 0);

        step = "rx_word";
        serve_read(32'h8, 32'h1); serve_read(32'h0, 32'hABCDEF11);
        serve_read(32'h8, 32'h1); serve_read(32'h0, 32'hABCDEF22);
        serve_read(32'h8, 32'h1); serve_read(32'h0, 32'hABCDEF33);
        chk("rx_not_yet", rx_valid, 0);
        serve_read(32'h8, 32'h1); serve_read(32'h0, 32'hABCDEF44);
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, 32'h44332211);

        step = "rx_full";
        for (int w = 1; w < 8; w++) begin
            for (int b = 0; b < 4; b++) begin
                serve_read(32'h8, 32'h1);
                serve_read(32'h0, {24'h0, 8'(16 * w + b)});
            end
        end
        serve_read(32'h8, 32'h1);
        serve_read(32'h8, 32'h1);
        chk("rx_head_kept", rx_data, 32'h44332211);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_after_pop", {31'b0, rx_valid}, 1);
        chk("rx_next_word", rx_data, 32'h13121110);
        serve_read(32'h8, 32'h1);
        serve_read(32'h0, 32'h55);

        step = "hs_order";
        push_byte(8'h50);
        serve_read(32'h8, 32'h4);
        serve_write(8'h50, 0, 2);
        push_byte(8'h51);
        serve_read(32'h8, 32'h4);
        serve_write(8'h51, 2, 0);
        serve_read(32'h8, 32'h4);
        @(negedge clk);
        chk("single_write", {axi_awvalid, axi_arvalid}, 2'b01);

        step = "rst_wr_resp";
        push_byte(8'h52);
        serve_read(32'h8, 32'h4);
        @(negedge clk);
        chk("aw_up", {axi_awvalid, axi_wvalid}, 2'b11);
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        @(negedge clk);
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        chk("in_wr_resp", {axi_awvalid, axi_wvalid, axi_bready, rx_valid}, 4'b0011);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rstn = 1'b1;
        serve_read(32'h8, 32'h4);
        serve_write(8'hAA, 0, 0);
        serve_read(32'h8, 32'h4);
        @(negedge clk);
        chk("tx_flushed", {axi_awvalid, axi_arvalid}, 2'b01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
